// File: rtl/pixel_window_pkg.sv
// Shared constants, FSM state type and frame-size decode for the pixel window generator.
package pixel_window_pkg;

  localparam int unsigned MAX_W  = 16;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  // Image width selected by the 2-bit size code; 11 aliases to 16.
  function automatic logic [4:0] size_to_width(input logic [1:0] size);
    logic [4:0] w;
    case (size)
      2'b00:   w = 5'd4;
      2'b01:   w = 5'd8;
      default: w = 5'd16;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Enabled shift register of MAX_W pixels with a run-time selectable output tap.
// With tap_i = W-1 the output is the pixel accepted W enables earlier, aligned with d_i.
module line_buffer #(
  parameter int unsigned PIX_W = 1,
  parameter int unsigned MAX_W = 16
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic [$clog2(MAX_W)-1:0] tap_i,
  input  logic [PIX_W-1:0]         d_i,
  output logic [PIX_W-1:0]         q_o
);

  logic [PIX_W-1:0] sr_q [MAX_W];

  // Shift only on accepted pixels; contents are left uncleared (stale data is masked upstream).
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < MAX_W; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[tap_i];

endmodule

// File: rtl/pixel_window_gen.sv
// Raster pixel fetch sequencer plus two-line buffer producing 3x3 neighbourhoods.
module pixel_window_gen #(
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned MAX_W  = pixel_window_pkg::MAX_W,
  parameter int unsigned ADDR_W = pixel_window_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           size,
  input  logic                 validData,
  input  logic [PIX_W-1:0]     pixel_in,
  output logic [ADDR_W-1:0]    pixel_addr,
  output logic                 busy,
  output logic [9*PIX_W-1:0]   win,
  output logic                 win_valid,
  output logic                 frame_done
);

  import pixel_window_pkg::*;

  localparam logic [ADDR_W-1:0] AddrOne = 1;

  state_e            state_q, state_d;
  logic [3:0]        wm1_q, wm1_d;    // latched W-1
  logic [3:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [4:0]        width_sel;
  logic [4:0]        width_m1;
  logic              accept;

  logic [PIX_W-1:0]   nb_q [9];
  logic [PIX_W-1:0]   nb_d [9];
  logic [PIX_W-1:0]   row_in [3];
  logic [9*PIX_W-1:0] win_q, win_next;
  logic [PIX_W-1:0]   lb0_q, lb1_q;

  assign width_sel = size_to_width(size);
  assign width_m1  = width_sel - 5'd1;

  // Next-state: frame sequencing, raster counters and address generation.
  always_comb begin
    state_d = state_q;
    wm1_d   = wm1_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          wm1_d   = width_m1[3:0];
          row_d   = 4'd0;
          col_d   = 4'd0;
          addr_d  = '0;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        if (validData) begin
          accept = 1'b1;
          addr_d = addr_q + AddrOne;
          if (col_q == wm1_q) begin
            col_d = 4'd0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
          if (row_q >= 4'd2 && col_q >= 4'd2) begin
            valid_d = 1'b1;
          end
          if (row_q == wm1_q && col_q == wm1_q) begin
            state_d = StIdle;
            row_d   = 4'd0;
            col_d   = 4'd0;
            addr_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wm1_q   <= 4'd0;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wm1_q   <= wm1_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  line_buffer #(
    .PIX_W (PIX_W),
    .MAX_W (MAX_W)
  ) u_lb0 (
    .clk_i (clk),
    .en_i  (accept),
    .tap_i (wm1_q),
    .d_i   (pixel_in),
    .q_o   (lb0_q)
  );

  line_buffer #(
    .PIX_W (PIX_W),
    .MAX_W (MAX_W)
  ) u_lb1 (
    .clk_i (clk),
    .en_i  (accept),
    .tap_i (wm1_q),
    .d_i   (lb0_q),
    .q_o   (lb1_q)
  );

  // Shifted neighbourhood and its packed form (element k at bits (8-k)*PIX_W).
  always_comb begin
    row_in[0] = lb1_q;
    row_in[1] = lb0_q;
    row_in[2] = pixel_in;
    win_next  = '0;
    for (int r = 0; r < 3; r++) begin
      nb_d[3*r]   = nb_q[3*r+1];
      nb_d[3*r+1] = nb_q[3*r+2];
      nb_d[3*r+2] = row_in[r];
    end
    for (int k = 0; k < 9; k++) begin
      win_next[(8-k)*PIX_W +: PIX_W] = nb_d[k];
    end
  end

  // 3x3 column shift registers advance on accepted pixels; win updates only for interior windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        nb_q[k] <= '0;
      end
      win_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < 9; k++) begin
        nb_q[k] <= nb_d[k];
      end
      if (valid_d) begin
        win_q <= win_next;
      end
    end
  end

  assign pixel_addr = addr_q;
  assign busy       = busy_q;
  assign win        = win_q;
  assign win_valid  = valid_q;
  assign frame_done = done_q;

endmodule
